// File: rtl/cache_fill_responder_if.sv
// rtl/cache_fill_responder_if.sv - request, write-back and fill channels between cache and backing memory
interface cache_fill_responder_if #(
   parameter int BLK_W  = 8,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [BLK_W-1:0]  req_block;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              wr_done;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   modport master (
      output req_valid, req_write, req_block, wr_valid, wr_data, rd_ready,
      input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
   );

   modport slave (
      input  req_valid, req_write, req_block, wr_valid, wr_data, rd_ready,
      output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/cache_fill_responder.sv
// rtl/cache_fill_responder.sv - handshaked backing memory servicing cache line fills and write-backs
module cache_fill_responder #(
   parameter int NUM_BLOCKS      = 256,
   parameter int WORDS_PER_BLOCK = 16,
   parameter int DATA_W          = 32,
   parameter int READ_LATENCY    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   cache_fill_responder_if.slave  bus,
   output logic                   busy,
   output logic [15:0]            num_reads,
   output logic [15:0]            num_writes
);
   localparam int BLK_W  = $clog2(NUM_BLOCKS);
   localparam int BEAT_W = $clog2(WORDS_PER_BLOCK);
   localparam int ADDR_W = BLK_W + BEAT_W;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_LAT, S_READ, S_WRITE, S_WACK} state_t;

   state_t              state_q;
   logic [BLK_W-1:0]    blk_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [LAT_W-1:0]    lat_q;
   logic                req_ready_q;
   logic                wr_ready_q;
   logic                wr_done_q;
   logic                rd_valid_q;
   logic                rd_last_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [15:0]         num_reads_q;
   logic [15:0]         num_writes_q;

   logic [BEAT_W-1:0]   beat_inc_d;
   logic [ADDR_W-1:0]   rd_addr_d;
   logic                mem_we_d;

   // Contents survive rst; only power-up starts them at zero.
   logic [DATA_W-1:0] mem_q [NUM_BLOCKS*WORDS_PER_BLOCK] = '{default: '0};

   // The first READ cycle fetches the current beat; later fetches look one beat ahead.
   always_comb begin
      beat_inc_d = beat_q + 1'b1;
      rd_addr_d  = {blk_q, rd_valid_q ? beat_inc_d : beat_q};
      mem_we_d   = (state_q == S_WRITE) && bus.wr_valid;
   end

   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[{blk_q, beat_q}] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         blk_q        <= '0;
         beat_q       <= '0;
         lat_q        <= '0;
         req_ready_q  <= 1'b1;
         wr_ready_q   <= 1'b0;
         wr_done_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_data_q    <= '0;
         num_reads_q  <= '0;
         num_writes_q <= '0;
      end else begin
         wr_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  blk_q       <= bus.req_block;
                  beat_q      <= '0;
                  req_ready_q <= 1'b0;
                  if (bus.req_write) begin
                     state_q    <= S_WRITE;
                     wr_ready_q <= 1'b1;
                  end else if (READ_LATENCY == 0) begin
                     state_q <= S_READ;
                  end else begin
                     state_q <= S_LAT;
                     lat_q   <= LAT_LOAD;
                  end
               end
            end
            S_LAT: begin
               if (lat_q == '0) begin
                  state_q <= S_READ;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            S_READ: begin
               if (!rd_valid_q) begin
                  rd_valid_q <= 1'b1;
                  rd_data_q  <= mem_q[rd_addr_d];
                  rd_last_q  <= (beat_q == LAST_BEAT);
               end else if (bus.rd_ready) begin
                  if (rd_last_q) begin
                     state_q     <= S_IDLE;
                     rd_valid_q  <= 1'b0;
                     rd_last_q   <= 1'b0;
                     req_ready_q <= 1'b1;
                     beat_q      <= '0;
                     num_reads_q <= num_reads_q + {15'b0, num_reads_q != 16'hFFFF};
                  end else begin
                     beat_q    <= beat_inc_d;
                     rd_data_q <= mem_q[rd_addr_d];
                     rd_last_q <= (beat_inc_d == LAST_BEAT);
                  end
               end
            end
            S_WRITE: begin
               if (bus.wr_valid) begin
                  beat_q <= beat_inc_d;
                  if (beat_q == LAST_BEAT) begin
                     state_q      <= S_WACK;
                     wr_ready_q   <= 1'b0;
                     wr_done_q    <= 1'b1;
                     num_writes_q <= num_writes_q + {15'b0, num_writes_q != 16'hFFFF};
                  end
               end
            end
            S_WACK: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.wr_ready  = wr_ready_q;
   assign bus.wr_done   = wr_done_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.rd_data   = rd_data_q;
   assign busy          = (state_q != S_IDLE);
   assign num_reads     = num_reads_q;
   assign num_writes    = num_writes_q;
endmodule

// File: tb/tb_cache_fill_responder.sv
// tb/tb_cache_fill_responder.sv - directed self-checking bench for cache_fill_responder
module tb_cache_fill_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy, busy0;
   logic [15:0] num_reads, num_writes, num_reads0, num_writes0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_words [16];

   cache_fill_responder_if bus ();
   cache_fill_responder_if bus0 ();

   cache_fill_responder #(.READ_LATENCY(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .busy(busy), .num_reads(num_reads), .num_writes(num_writes)
   );

   cache_fill_responder #(.READ_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .busy(busy0), .num_reads(num_reads0), .num_writes(num_writes0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_blk(input logic [7:0] blk, input bit stall, input int exp_lat);
      int n, got, cyc;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++; $display("FAIL fill_req_ready blk=%h got %b want 1", blk, bus.req_ready);
      end
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_block = blk; bus.rd_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      do begin tick(); n++; end while (bus.rd_valid !== 1'b1 && n < 50);
      n_cmp++;
      if (n != exp_lat) begin
         n_fail++; $display("FAIL fill_latency blk=%h got %0d want %0d", blk, n, exp_lat);
      end
      got = 0; cyc = 0;
      while (got < 16 && cyc < 200) begin
         n_cmp++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_words[got] || bus.rd_last !== (got == 15)) begin
            n_fail++;
            $display("FAIL fill_beat blk=%h beat %0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                     blk, got, bus.rd_valid, bus.rd_data, bus.rd_last, exp_words[got], got == 15);
         end
         bus.rd_ready = stall ? (cyc % 3 == 0) : 1'b1;
         tick();
         if (bus.rd_ready) got++;
         cyc++;
      end
      bus.rd_ready = 1'b0;
      n_cmp++;
      if (got != 16 || bus.rd_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL fill_end blk=%h got beats=%0d rd_valid=%b busy=%b want 16 0 0",
                            blk, got, bus.rd_valid, busy);
      end
   endtask

   task automatic do_write(input logic [7:0] blk, input int nb, input int base);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_block = blk;
      tick();
      bus.req_valid = 1'b0; bus.req_write = 1'b0;
      for (int i = 0; i < nb; i++) begin
         n_cmp++;
         if (bus.wr_ready !== 1'b1 || bus.wr_done !== 1'b0) begin
            n_fail++; $display("FAIL wr_beat %0d got wr_ready=%b wr_done=%b want 1 0", i, bus.wr_ready, bus.wr_done);
         end
         bus.wr_valid = 1'b1; bus.wr_data = 32'(base + i);
         tick();
      end
      bus.wr_valid = 1'b0;
      if (nb == 16) begin
         n_cmp++;
         if (bus.wr_done !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_pulse got wr_done=%b req_ready=%b want 1 0", bus.wr_done, bus.req_ready);
         end
         tick();
         n_cmp++;
         if (bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_end got wr_done=%b req_ready=%b busy=%b want 0 1 0",
                               bus.wr_done, bus.req_ready, busy);
         end
      end
   endtask

   task automatic test_reset();
      tick();
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 ||
          bus.wr_done !== 1'b0 || busy !== 1'b0 || bus.rd_data !== 32'd0) begin
         n_fail++; $display("FAIL reset_outputs got rr=%b wr=%b rv=%b rl=%b wd=%b busy=%b rd=%0d want 1 0 0 0 0 0 0",
                            bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.wr_done, busy, bus.rd_data);
      end
      n_cmp++;
      if (num_reads !== 16'd0 || num_writes !== 16'd0) begin
         n_fail++; $display("FAIL reset_counters got %0d %0d want 0 0", num_reads, num_writes);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill_zero();
      for (int i = 0; i < 16; i++) exp_words[i] = 32'd0;
      fill_blk(8'h22, 1'b0, 5);
      n_cmp++;
      if (num_reads !== 16'd1) begin
         n_fail++; $display("FAIL fill_zero_count got %0d want 1", num_reads);
      end
   endtask

   task automatic test_write_back();
      do_write(8'h22, 16, 100);
      n_cmp++;
      if (num_writes !== 16'd1) begin
         n_fail++; $display("FAIL write_count got %0d want 1", num_writes);
      end
      for (int i = 0; i < 16; i++) exp_words[i] = 32'(100 + i);
      fill_blk(8'h22, 1'b0, 5);
   endtask

   task automatic test_fill_stall();
      for (int i = 0; i < 16; i++) exp_words[i] = 32'(100 + i);
      fill_blk(8'h22, 1'b1, 5);
      n_cmp++;
      if (num_reads !== 16'd3) begin
         n_fail++; $display("FAIL stall_count got %0d want 3", num_reads);
      end
   endtask

   task automatic test_reset_mid_write();
      do_write(8'h05, 6, 500);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1 || bus.wr_ready !== 1'b0 || num_writes !== 16'd0) begin
         n_fail++; $display("FAIL midwrite_reset got busy=%b wd=%b rr=%b wr=%b nw=%0d want 0 0 1 0 0",
                            busy, bus.wr_done, bus.req_ready, bus.wr_ready, num_writes);
      end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (bus.wr_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midwrite_after got wd=%b busy=%b want 0 0", bus.wr_done, busy);
      end
      for (int i = 0; i < 16; i++) exp_words[i] = (i < 6) ? 32'(500 + i) : 32'd0;
      fill_blk(8'h05, 1'b0, 5);
   endtask

   task automatic test_lat0_back_to_back();
      int n, got;
      bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_block = 8'h22; bus0.rd_ready = 1'b1;
      tick();
      n = 0;
      do begin tick(); n++; end while (bus0.rd_valid !== 1'b1 && n < 50);
      n_cmp++;
      if (n != 1) begin
         n_fail++; $display("FAIL lat0_latency got %0d want 1", n);
      end
      got = 0;
      while (got < 16) begin
         n_cmp++;
         if (bus0.rd_valid !== 1'b1 || bus0.req_ready !== 1'b0 || bus0.rd_last !== (got == 15)) begin
            n_fail++; $display("FAIL lat0_beat %0d got rv=%b rr=%b rl=%b want 1 0 %b",
                               got, bus0.rd_valid, bus0.req_ready, bus0.rd_last, got == 15);
         end
         tick();
         got++;
      end
      n_cmp++;
      if (bus0.rd_valid !== 1'b0 || bus0.req_ready !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL lat0_idle got rv=%b rr=%b busy=%b want 0 1 0", bus0.rd_valid, bus0.req_ready, busy0);
      end
      tick();
      bus0.req_valid = 1'b0;
      n_cmp++;
      if (busy0 !== 1'b1 || bus0.req_ready !== 1'b0) begin
         n_fail++; $display("FAIL lat0_second_accept got busy=%b rr=%b want 1 0", busy0, bus0.req_ready);
      end
      n = 0;
      while (busy0 === 1'b1 && n < 100) begin tick(); n++; end
      n_cmp++;
      if (num_reads0 !== 16'd2 || n != 17) begin
         n_fail++; $display("FAIL lat0_second_burst got reads=%0d cycles=%0d want 2 17", num_reads0, n);
      end
      bus0.rd_ready = 1'b0;
   endtask

   task automatic test_saturation();
      force dut.num_writes_q = 16'hFFFE;
      tick();
      release dut.num_writes_q;
      tick();
      n_cmp++;
      if (num_writes !== 16'hFFFE) begin
         n_fail++; $display("FAIL sat_preload got %h want fffe", num_writes);
      end
      do_write(8'h40, 16, 7);
      n_cmp++;
      if (num_writes !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_reach got %h want ffff", num_writes);
      end
      do_write(8'h40, 16, 9);
      n_cmp++;
      if (num_writes !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_hold got %h want ffff", num_writes);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_block = '0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
      bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_block = '0;
      bus0.wr_valid = 1'b0; bus0.wr_data = '0; bus0.rd_ready = 1'b0;
      test_reset();
      test_fill_zero();
      test_write_back();
      test_fill_stall();
      test_reset_mid_write();
      test_lat0_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/cache_fill_responder.md
Name: cache_fill_responder

Overview:
- Backing-memory end of the cache-to-memory block interface.
- Services line-fill (read) and write-back (write) requests issued by the 4-way, 8-set cache.
- Holds 256 blocks of 16 words each and moves one word per beat over valid/ready channels.
- Sits directly below the cache controller.
- Replaces the cache model's direct array access with a timed, handshaked memory.

Parameters:
- NUM_BLOCKS, 256, number of memory blocks; block index width is log2(NUM_BLOCKS) = 8.
- WORDS_PER_BLOCK, 16, words per block; beat counter width is 4.
- DATA_W, 32, word width in bits.
- READ_LATENCY, 4, idle cycles between read-request acceptance and the first read beat; 0 is legal.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write-back, 0 = line fill.
- req_block  input  8  block index, equal to address[11:4].
- wr_valid  input  1  write-back beat present.
- wr_ready  output  1  responder accepts the write beat.
- wr_data  input  32  write-back word.
- wr_done  output  1  one-cycle pulse when a write-back completes.
- rd_valid  output  1  fill beat present.
- rd_ready  input  1  cache accepts the fill beat.
- rd_data  output  32  fill word.
- rd_last  output  1  marks beat 15 of a fill.
- busy  output  1  high in any state other than IDLE.
- num_reads  output  16  completed fills, saturating.
- num_writes  output  16  completed write-backs, saturating.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; beat counter, latency counter, num_reads and num_writes clear to 0.
  - Outputs: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, wr_done=0, busy=0, rd_data=0.
  - Memory contents are not cleared by rst. They are zero at time 0.
- States: IDLE, LAT, READ, WRITE, WACK.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_block and clear beat to 0.
  - If req_write=1, go to WRITE.
  - If req_write=0: go to LAT with the latency counter loaded to READ_LATENCY-1, or go straight to READ when READ_LATENCY=0.
  - wr_valid is ignored in IDLE.
- LAT:
  - Latency counter decrements each cycle.
  - Go to READ on the cycle after the counter reads 0, so the first rd_valid appears exactly READ_LATENCY+1 cycles after the accepting edge.
- READ:
  - rd_valid=1 and rd_data=mem[blk][beat], both registered so they are stable while rd_ready=0.
  - rd_last=1 when beat=15.
  - On rd_valid&&rd_ready the beat increments.
  - On the last accepted beat: go to IDLE, increment num_reads, drop rd_valid the next cycle.
  - rd_ready low stalls with no data change.
- WRITE:
  - wr_ready=1.
  - On wr_valid, write mem[blk][beat]=wr_data and increment the beat.
  - After beat 15 is written, go to WACK.
- WACK:
  - Lasts exactly one cycle, with wr_done=1 and num_writes incremented.
  - Then go to IDLE; req_ready is not asserted during WACK.
- Beat counter: 4 bits, wraps 15 to 0 only at burst end, never mid-burst.
- Counters: num_reads and num_writes hold at 0xFFFF and never wrap.
- No overlap: one request is in flight at a time. Requests presented while busy stay pending, since req_ready=0.
- Reset mid-WRITE: words already written stay in memory, the remaining words are unchanged, and no wr_done is issued.
- Reset mid-READ: the burst is abandoned and rd_valid drops asynchronously.
- Read after write to the same block returns the new data. No forwarding is needed because requests are serialized.

Test Plan:
- After reset, fill block 0x22 with rd_ready held 1 → first rd_valid 5 cycles after acceptance; 16 beats of 0; rd_last on the 16th beat; num_reads=1.
- Write-back to block 0x22 with wr_data=100+i on beat i → wr_done pulses 1 cycle after beat 15. A following fill of 0x22 returns 100..115 in order; num_writes=1.
- Fill block 0x22 with rd_ready toggled 1,0,0,1... → rd_data and rd_last hold during stalls; exactly 16 beats delivered; no beat skipped or duplicated.
- Write-back to block 0x05 with rst asserted after 6 beats → state IDLE, busy=0, no wr_done. A subsequent fill returns the 6 written words followed by 10 zeros.
- READ_LATENCY=0 build: fill request → rd_valid 1 cycle after acceptance.
  - Also hold req_valid during the burst: a second request is accepted only in IDLE, after rd_last completes.
- Force num_writes to 0xFFFF via 65535 back-to-back write-backs (or a preload hook) → one more write-back leaves it at 0xFFFF.
